// File: rtl/merge_req_fifo.sv
// merge_req_fifo: capture FIFO behind the 3-way mutex merge. Synchronises the drive/free
// handshake into clk and presents tags first-word fall-through. Optional macro: MERGE_REQ_FIFO_STATS_EN.
module merge_req_fifo #(
  parameter int DATA_W      = 5,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_drive,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_free,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready
`ifdef MERGE_REQ_FIFO_STATS_EN
  ,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [15:0]            o_stall_cnt,
  output logic [$clog2(DEPTH):0] o_hwm
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, STALL, ACK} state_t;

  state_t                  state, state_next;
  logic [SYNC_STAGES-1:0]  sync;
  logic                    sync_prev;
  logic                    req_edge;
  logic [DATA_W-1:0]       mem [DEPTH];
  logic [AW-1:0]           wptr, rptr;
  logic [CW-1:0]           count, count_next;
  logic [DATA_W-1:0]       data_hold;
  logic                    push, pop, push_ok;

  // Drive is asynchronous to clk; only a rising edge of the synchronised level is a request.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], i_drive};
      sync_prev <= sync[SYNC_STAGES-1];
    end
  end

  assign req_edge = sync[SYNC_STAGES-1] & ~sync_prev;
  assign o_valid  = (count != '0);
  assign pop      = o_valid & i_ready;
  assign push_ok  = (count < CW'(DEPTH)) | pop;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    o_free     = 1'b0;
    case (state)
      IDLE: begin
        if (req_edge) begin
          if (push_ok) begin
            push       = 1'b1;
            state_next = ACK;
          end else begin
            state_next = STALL;
          end
        end
      end
      STALL: begin
        if (push_ok) begin
          push       = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        o_free     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= i_data;
  end

  // data_hold keeps the last presented tag so o_data does not jump to stale slots when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      data_hold <= '0;
    end else begin
      if (push)    wptr      <= wptr + 1'b1;
      if (pop)     rptr      <= rptr + 1'b1;
      if (o_valid) data_hold <= mem[rptr];
      count <= count_next;
    end
  end

  assign o_data = o_valid ? mem[rptr] : data_hold;

`ifdef MERGE_REQ_FIFO_STATS_EN
  logic [15:0]   stall_cnt;
  logic [CW-1:0] hwm;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      hwm       <= '0;
    end else begin
      if ((state == STALL) && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 1'b1;
      if (count_next > hwm) hwm <= count_next;
    end
  end

  assign o_count     = count;
  assign o_stall_cnt = stall_cnt;
  assign o_hwm       = hwm;
`endif

endmodule

// File: tb/tb_merge_req_fifo.sv
// tb_merge_req_fifo: directed bench for merge_req_fifo; expected tags are queued at issue
// and a negedge monitor pops and compares them on every consumer handshake.
`timescale 1ns/1ps
module tb_merge_req_fifo;

  localparam int DATA_W = 5;
  localparam int DEPTH  = 4;
  localparam int CW     = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_drive;
  logic [DATA_W-1:0] i_data;
  logic              o_free;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              i_ready;
`ifdef MERGE_REQ_FIFO_STATS_EN
  logic [CW-1:0]     o_count;
  logic [15:0]       o_stall_cnt;
  logic [CW-1:0]     o_hwm;
`endif

  int                n_checks = 0;
  int                n_fail   = 0;
  logic [DATA_W-1:0] sb_q[$];
  logic [DATA_W-1:0] exp_tag;
  logic              prev_free = 1'b0;
  bit                track_run = 1'b0;
  int                valid_run = 0;
  int                max_valid_run = 0;

  merge_req_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .i_drive(i_drive), .i_data(i_data), .o_free(o_free),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready)
`ifdef MERGE_REQ_FIFO_STATS_EN
    , .o_count(o_count), .o_stall_cnt(o_stall_cnt), .o_hwm(o_hwm)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  // Raise drive with a tag, hold it until o_free is seen (bounded), then release.
  task automatic applyStimulus(input logic [DATA_W-1:0] tag, output bit acked);
    i_data  = tag;
    i_drive = 1'b1;
    acked   = 1'b0;
    for (int k = 0; k < 20 && !acked; k++) begin
      to_neg();
      if (o_free) acked = 1'b1;
    end
    step();
    i_drive = 1'b0;
    repeat (2) step();
  endtask

  // Monitor: every consumer handshake must deliver the oldest expected tag.
  always @(negedge clk) begin
    if (rst) begin
      prev_free = 1'b0;
      valid_run = 0;
    end else begin
      if (o_valid && i_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL pop_order: got 0x%0h, expected no pop (scoreboard empty)", o_data);
        end else begin
          exp_tag = sb_q.pop_front();
          checkOutput("pop_order", 32'(o_data), 32'(exp_tag));
        end
      end
      if (o_free) checkOutput("free_single_cycle", 32'(prev_free), 32'd0);
      prev_free = o_free;
      if (track_run) begin
        valid_run = o_valid ? valid_run + 1 : 0;
        if (valid_run > max_valid_run) max_valid_run = valid_run;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acked;
    int acks;
    int stray;
    int free_cnt;
    int free_at;

    rst = 1'b1; i_drive = 1'b0; i_ready = 1'b0; i_data = '0;
    repeat (2) step();
    to_neg();
    checkOutput("reset_valid", 32'(o_valid), 32'd0);
    checkOutput("reset_free",  32'(o_free),  32'd0);
    checkOutput("reset_data",  32'(o_data),  32'd0);
`ifdef MERGE_REQ_FIFO_STATS_EN
    checkOutput("reset_stall_cnt", 32'(o_stall_cnt), 32'd0);
    checkOutput("reset_hwm",       32'(o_hwm),       32'd0);
`endif
    step();
    rst = 1'b0;
    step();

    $display("[TB] single request");
    i_ready = 1'b1; i_data = 5'h15; i_drive = 1'b1;
    sb_q.push_back(5'h15);
    step(); step();
    i_drive = 1'b0;
    to_neg();
    checkOutput("single_free_before_write",  32'(o_free),  32'd0);
    checkOutput("single_valid_before_write", 32'(o_valid), 32'd0);
    step(); to_neg();
    checkOutput("single_free_after_write",  32'(o_free),  32'd1);
    checkOutput("single_valid_after_write", 32'(o_valid), 32'd1);
    checkOutput("single_data",              32'(o_data),  32'h15);
    step(); to_neg();
    checkOutput("single_free_done",  32'(o_free),  32'd0);
    checkOutput("single_valid_done", 32'(o_valid), 32'd0);
    step();

    $display("[TB] fill to full");
    i_ready = 1'b0;
    acks = 0;
    for (int t = 1; t <= 4; t++) begin
      sb_q.push_back(5'(t));
      applyStimulus(5'(t), acked);
      if (acked) acks++;
    end
    checkOutput("fill_acks", 32'(acks), 32'd4);
    to_neg();
    checkOutput("fill_valid", 32'(o_valid), 32'd1);
    checkOutput("fill_head",  32'(o_data),  32'h01);
`ifdef MERGE_REQ_FIFO_STATS_EN
    checkOutput("fill_count", 32'(o_count), 32'd4);
    checkOutput("fill_hwm",   32'(o_hwm),   32'd4);
`endif
    step();

    $display("[TB] stall and release");
    i_data = 5'h05; i_drive = 1'b1;
    sb_q.push_back(5'h05);
    stray = 0;
    for (int k = 0; k < 9; k++) begin
      to_neg();
      if (o_free) stray++;
      step();
    end
    checkOutput("full_no_free", 32'(stray), 32'd0);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    to_neg();
    checkOutput("release_free", 32'(o_free), 32'd1);
`ifdef MERGE_REQ_FIFO_STATS_EN
    checkOutput("release_stall_cnt", 32'(o_stall_cnt), 32'd7);
    checkOutput("release_count",     32'(o_count),     32'd4);
    checkOutput("release_hwm",       32'(o_hwm),       32'd4);
`endif
    step();
    i_drive = 1'b0;
    i_ready = 1'b1;
    repeat (8) step();
    to_neg();
    checkOutput("drain_valid", 32'(o_valid), 32'd0);
    checkOutput("drain_sb_empty", 32'(sb_q.size()), 32'd0);
    step();

    $display("[TB] wrap-around");
    acks = 0;
    max_valid_run = 0;
    track_run = 1'b1;
    for (int t = 0; t < 10; t++) begin
      sb_q.push_back(5'(t));
      applyStimulus(5'(t), acked);
      if (acked) acks++;
    end
    track_run = 1'b0;
    checkOutput("wrap_acks", 32'(acks), 32'd10);
    checkOutput("wrap_max_occupancy", 32'(max_valid_run), 32'd1);
    checkOutput("wrap_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] reset mid-operation");
    i_ready = 1'b0;
    for (int t = 10; t < 14; t++) begin
      applyStimulus(5'(t), acked);
      checkOutput("pre_reset_ack", 32'(acked), 32'd1);
    end
    i_data = 5'h1C; i_drive = 1'b1;
    repeat (6) step();
    to_neg();
    checkOutput("pre_reset_no_free", 32'(o_free),  32'd0);
    checkOutput("pre_reset_head",    32'(o_data),  32'h0A);
    step();
    rst = 1'b1;
    sb_q.delete();
    step();
    rst = 1'b0;
    to_neg();
    checkOutput("post_reset_valid", 32'(o_valid), 32'd0);
    checkOutput("post_reset_free",  32'(o_free),  32'd0);
    checkOutput("post_reset_data",  32'(o_data),  32'd0);
`ifdef MERGE_REQ_FIFO_STATS_EN
    checkOutput("post_reset_stall_cnt", 32'(o_stall_cnt), 32'd0);
    checkOutput("post_reset_count",     32'(o_count),     32'd0);
`endif
    sb_q.push_back(5'h1C);
    free_cnt = 0;
    free_at  = 0;
    for (int k = 1; k <= 8; k++) begin
      step(); to_neg();
      if (o_free) begin
        free_cnt++;
        free_at = k;
      end
    end
    checkOutput("held_drive_free_count", 32'(free_cnt), 32'd1);
    checkOutput("held_drive_free_cycle", 32'(free_at),  32'd3);
    checkOutput("held_drive_valid",      32'(o_valid),  32'd1);
    checkOutput("held_drive_data",       32'(o_data),   32'h1C);
    step();
    i_drive = 1'b0;
    i_ready = 1'b1;
    repeat (4) step();
    to_neg();
    checkOutput("final_valid", 32'(o_valid), 32'd0);
    checkOutput("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
